// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the shared-multiplier scheduler.
package mult_sched_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned N_REQ_DEF = 2;
  localparam int unsigned N_REQ_MAX = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // First set bit of valid[0 +: n], searching upward from ptr with wrap.
  // Falls back to ptr when nothing is set; callers gate on any-valid.
  function automatic logic [1:0] rr_pick(input logic [3:0] valid,
                                         input logic [1:0] ptr,
                                         input int unsigned n);
    logic        found;
    int unsigned idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < N_REQ_MAX; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (!found && (k < n) && valid[idx[1:0]]) begin
        rr_pick = idx[1:0];
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mult_sched_4b_rr_arbiter.sv
// Round-robin grant for the shared multiplier; grants only while enabled.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] i_valid,
  input  logic [1:0]       i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_grant,
  output logic [1:0]       o_idx
);

  logic [3:0] w_valid4;

  // One-hot grant of the first valid requester at or above the pointer.
  always_comb begin
    w_valid4              = '0;
    w_valid4[N_REQ-1:0]   = i_valid;
    o_idx                 = rr_pick(w_valid4, i_ptr, N_REQ);
    o_grant               = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      o_grant[k] = i_en && i_valid[k] && (32'(o_idx) == k);
    end
  end

endmodule

// File: rtl/mult_sched_4b.sv
// Schedules one shared combinational multiplier among N_REQ requesters:
// round-robin accept, fixed-latency wait, per-requester response.
module mult_sched_4b
  import mult_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned N_REQ   = N_REQ_DEF,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [2*WIDTH-1:0]     rsp_result,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic [2*WIDTH-1:0]     mul_result,
  output logic                   busy
);

  state_t               r_state;
  logic [1:0]           r_ptr;
  logic [1:0]           r_owner;
  logic [3:0]           r_lat;
  logic [WIDTH-1:0]     r_mul_a;
  logic [WIDTH-1:0]     r_mul_b;
  logic [2*WIDTH-1:0]   r_rsp_result;
  logic [N_REQ-1:0]     r_rsp_valid;
  logic                 r_busy;

  logic                 w_en;
  logic [N_REQ-1:0]     w_grant;
  logic [1:0]           w_idx;
  logic [WIDTH-1:0]     w_a;
  logic [WIDTH-1:0]     w_b;
  logic [N_REQ-1:0]     w_owner_oh;
  logic                 w_rsp_hs;
  logic [1:0]           w_next_ptr;

  // Grants only in IDLE and never while reset is asserted.
  assign w_en = (r_state == IDLE) && rstn;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_en),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // Operand mux for the granted requester, owner one-hot and response handshake.
  always_comb begin
    w_a        = '0;
    w_b        = '0;
    w_owner_oh = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_grant[k]) begin
        w_a = req_a[k*WIDTH +: WIDTH];
        w_b = req_b[k*WIDTH +: WIDTH];
      end
      w_owner_oh[k] = (32'(r_owner) == k);
    end
    w_rsp_hs   = |(rsp_ready & r_rsp_valid);
    w_next_ptr = (32'(r_owner) == N_REQ - 1) ? 2'd0 : r_owner + 2'd1;
  end

  // Control FSM with registered operands, result, response valid and busy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_lat        <= '0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_rsp_result <= '0;
      r_rsp_valid  <= '0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_mul_a <= w_a;
            r_mul_b <= w_b;
            r_owner <= w_idx;
            r_lat   <= 4'(MUL_LAT - 1);
            r_busy  <= 1'b1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_lat == '0) begin
            r_rsp_result <= mul_result;
            r_rsp_valid  <= w_owner_oh;
            r_state      <= RESP;
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        RESP: begin
          if (w_rsp_hs) begin
            r_ptr       <= w_next_ptr;
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = w_grant;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign busy       = r_busy;

endmodule

// File: tb/tb_mult_sched_4b.sv
// Bench for mult_sched_4b: two instances (MUL_LAT=1 and MUL_LAT=3), each
// checked every cycle against a transaction-level model.
module tb_mult_sched_4b;

  localparam int unsigned W = 4;
  localparam int unsigned N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int bad    = 0;
  int n_done = 0;

  task automatic chk(input string name, input int lane, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lane=%0d cyc=%0d actual=%0h required=%0h",
               name, lane, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned LAT = (g == 0) ? 1 : 3;

    logic             rstn;
    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0]   req_a, req_b;
    logic [2*W-1:0]   rsp_result, mul_result;
    logic [W-1:0]     mul_a, mul_b;
    logic             busy;

    // Combinational 4x4 unsigned array-multiplier equivalent.
    assign mul_result = {4'b0, mul_a} * {4'b0, mul_b};

    mult_sched_4b #(.WIDTH(W), .N_REQ(N), .MUL_LAT(LAT)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_result (mul_result),
      .busy       (busy)
    );

    // Model: one pending operation, its product and the cycle its response appears.
    int         cyc = 0;
    int         m_ptr = 0, m_owner = 0, m_resp_at = 0;
    bit         m_have = 0;
    logic [7:0] m_prod = '0, m_res = '0;
    logic [3:0] m_ma = '0, m_mb = '0;

    // Requester-side stimulus state.
    bit         sv [N];
    logic [3:0] sa [N];
    logic [3:0] sb [N];
    logic [N-1:0] srdy = '0;
    bit         rand_mode = 0;

    // Per-step observations for directed sequences.
    bit         ev_acc;
    int         ev_idx, ev_cyc;
    logic [N-1:0] last_rv;
    int         last_hs = -1;

    function automatic int pick();
      for (int k = 0; k < int'(N); k++) begin
        int idx;
        idx = (m_ptr + k) % int'(N);
        if (sv[idx]) return idx;
      end
      return -1;
    endfunction

    task automatic step(input bit rst_low);
      logic [N-1:0] exp_rr, exp_rv;
      logic [31:0]  r;
      int           p;
      @(negedge clk);
      if (rand_mode) begin
        for (int i = 0; i < int'(N); i++) begin
          if (!sv[i] && $urandom_range(0, 2) == 0) begin
            sv[i] = 1'b1;
            r = $urandom; sa[i] = r[3:0];
            r = $urandom; sb[i] = r[3:0];
          end
        end
        r = $urandom;
        srdy = r[N-1:0];
      end
      rstn = !rst_low;
      for (int i = 0; i < int'(N); i++) begin
        req_valid[i]       = sv[i];
        req_a[i*W +: W]    = sa[i];
        req_b[i*W +: W]    = sb[i];
      end
      rsp_ready = srdy;
      #1;
      if (!rstn) begin
        m_ptr = 0; m_owner = 0; m_have = 0;
        m_res = '0; m_ma = '0; m_mb = '0;
      end else if (m_have && cyc == m_resp_at) begin
        m_res = m_prod;
      end
      exp_rr = '0;
      p = -1;
      if (rstn && !m_have) begin
        p = pick();
        if (p >= 0) exp_rr[p] = 1'b1;
      end
      exp_rv = '0;
      if (m_have && cyc >= m_resp_at) exp_rv[m_owner] = 1'b1;
      chk("req_ready",  g, cyc, 32'(req_ready),  32'(exp_rr));
      chk("rsp_valid",  g, cyc, 32'(rsp_valid),  32'(exp_rv));
      chk("rsp_result", g, cyc, 32'(rsp_result), 32'(m_res));
      chk("mul_a",      g, cyc, 32'(mul_a),      32'(m_ma));
      chk("mul_b",      g, cyc, 32'(mul_b),      32'(m_mb));
      chk("busy",       g, cyc, 32'(busy),       32'(m_have));
      ev_acc  = 0;
      ev_cyc  = cyc;
      last_rv = exp_rv;
      if (rstn) begin
        if (exp_rv != '0 && srdy[m_owner]) begin
          m_have  = 0;
          m_ptr   = (m_owner + 1) % int'(N);
          last_hs = cyc;
        end else if (p >= 0) begin
          m_have    = 1;
          m_owner   = p;
          m_prod    = 8'({4'b0, sa[p]} * {4'b0, sb[p]});
          m_resp_at = cyc + 1 + int'(LAT);
          m_ma      = sa[p];
          m_mb      = sb[p];
          sv[p]     = 1'b0;
          ev_acc    = 1;
          ev_idx    = p;
        end
      end
      cyc++;
    endtask

    // One operation by requester idx; hold>0 delays rsp_ready that many RESP cycles.
    task automatic run_single(input int idx, input logic [3:0] a, input logic [3:0] b,
                              input logic [7:0] exp_lit, input int exp_lat,
                              input int exp_acc, input int hold);
      int acc_c, rv_c;
      bit got;
      sv[idx] = 1'b1; sa[idx] = a; sb[idx] = b;
      srdy = '0;
      if (hold == 0) srdy[idx] = 1'b1;
      acc_c = -1; rv_c = -1; got = 0;
      for (int n = 0; n < 40 && !got; n++) begin
        step(0);
        if (ev_acc) acc_c = ev_cyc;
        if (last_rv != '0) begin got = 1; rv_c = ev_cyc; end
      end
      chk("rsp_seen",    g, cyc, 32'(got),        32'd1);
      chk("lit_product", g, cyc, 32'(rsp_result), 32'(exp_lit));
      chk("lit_model",   g, cyc, 32'(m_prod),     32'(exp_lit));
      chk("latency",     g, cyc, 32'(rv_c - acc_c), 32'(exp_lat));
      if (exp_acc >= 0) chk("accept_cycle", g, cyc, 32'(acc_c), 32'(exp_acc));
      for (int h = 0; h < hold; h++) begin
        step(0);
        chk("bp_valid",  g, cyc, 32'(rsp_valid),  32'(1 << idx));
        chk("bp_result", g, cyc, 32'(rsp_result), 32'(exp_lit));
        chk("bp_ready",  g, cyc, 32'(req_ready),  32'd0);
      end
      if (hold > 0) begin
        srdy[idx] = 1'b1;
        step(0);
      end
      srdy = '0;
    endtask

    initial begin
      for (int i = 0; i < int'(N); i++) begin sv[i] = 0; sa[i] = '0; sb[i] = '0; end
      step(1);
      step(1);
      if (g == 0) begin
        run_single(0, 4'd3, 4'd5, 8'h0F, 2, 2, 0);
        run_single(0, 4'hF, 4'hF, 8'hE1, 2, 5, 0);
        run_single(1, 4'd0, 4'd9, 8'h00, 2, 8, 0);
        sv[1] = 1'b1; sa[1] = 4'd2; sb[1] = 4'd2;
        run_single(0, 4'd5, 4'd5, 8'h19, 2, -1, 5);
        srdy = '1;
        for (int i = 0; i < 6; i++) step(0);
        // Contention from reset: both keep requesting, grants must alternate.
        step(1);
        begin
          int seen;
          logic [N-1:0] exp_oh;
          seen = 0;
          sv[0] = 1'b1; sv[1] = 1'b1; srdy = '1;
          for (int n = 0; n < 30 && seen < 3; n++) begin
            step(0);
            if (ev_acc) begin
              exp_oh = (seen == 1) ? 2'b10 : 2'b01;
              chk("contend_grant", g, cyc, 32'(req_ready), 32'(exp_oh));
              sv[ev_idx] = 1'b1;
              seen++;
            end
          end
          chk("contend_count", g, cyc, 32'(seen), 32'd3);
        end
      end else begin
        run_single(0, 4'd7, 4'd6, 8'h2A, 4, 2, 0);
        // Reset while WAIT is in progress; pointer was 1 before the reset.
        sv[1] = 1'b1; sa[1] = 4'd9; sb[1] = 4'd9; srdy = '0;
        begin
          bit acc;
          acc = 0;
          for (int n = 0; n < 10 && !acc; n++) begin step(0); acc = ev_acc; end
          chk("midwait_accept", g, cyc, 32'(acc), 32'd1);
        end
        step(0);
        step(1);
        chk("rst_busy",   g, cyc, 32'(busy),      32'd0);
        chk("rst_rv",     g, cyc, 32'(rsp_valid), 32'd0);
        chk("rst_result", g, cyc, 32'(rsp_result), 32'd0);
        step(1);
        sv[0] = 1'b1; sv[1] = 1'b1; sa[0] = 4'd1; sb[0] = 4'd1;
        step(0);
        chk("post_rst_grant", g, cyc, 32'(req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
          step(0);
          chk("no_stale_rv", g, cyc, 32'(rsp_valid == '0 || m_have), 32'd1);
        end
      end
      rand_mode = 1;
      for (int i = 0; i < 400; i++) step(0);
      rand_mode = 0;
      n_done++;
    end
  end

  initial begin
    fork
      wait (n_done == 2);
      #100000;
    join_any
    if (n_done != 2) begin
      bad++;
      $display("FAIL watchdog lanes_done actual=%0d required=2", n_done);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
